// File: rtl/local_store_responder.sv
// Local-store responder for the SPU core: single-port quadword array serving the odd-pipe
// load/store port and the instruction-fetch port, with a one-line fetch buffer.
module local_store_responder #(
    parameter int ADDR_W = 15,
    parameter int RD_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ls_req,
    input  logic              ls_wrt_en,
    input  logic [ADDR_W-1:0] ls_address,
    input  logic [127:0]      ls_data_input,
    output logic [127:0]      ls_data_output,
    output logic              ls_rvalid,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_address,
    output logic              if_ready,
    output logic [127:0]      if_data,
    output logic              if_rvalid
);

    localparam int LINE_W = ADDR_W - 4;
    localparam int DEPTH  = 2 ** LINE_W;

    logic [127:0]      mem [DEPTH];

    logic [LINE_W-1:0] ls_line;
    logic [LINE_W-1:0] if_line;
    logic              store;
    logic              load;
    logic              fetch_hit;
    logic              fetch_from_array;
    logic [127:0]      fetch_word;

    logic              buf_valid;
    logic [LINE_W-1:0] buf_tag;
    logic [127:0]      buf_data;

    logic [RD_LAT-1:0] ls_vld;
    logic [RD_LAT-1:0] if_vld;
    logic [127:0]      ls_pipe [RD_LAT];
    logic [127:0]      if_pipe [RD_LAT];

    logic              unused_offset;

    // Byte offset within a quadword carries no meaning for the array.
    assign unused_offset = ^{ls_address[3:0], if_address[3:0]};

    assign ls_line = ls_address[ADDR_W-1:4];
    assign if_line = if_address[ADDR_W-1:4];
    assign store   = ls_req && ls_wrt_en;
    assign load    = ls_req && !ls_wrt_en;

    // A store to the buffered line in the same cycle makes the buffered copy stale.
    always_comb begin
        fetch_hit        = 1'b0;
        if_ready         = 1'b0;
        fetch_from_array = 1'b0;
        fetch_word       = buf_data;
        if (buf_valid && (buf_tag == if_line) && !(store && (ls_line == if_line))) begin
            fetch_hit = 1'b1;
        end
        if (!reset && if_req && (!ls_req || fetch_hit)) begin
            if_ready = 1'b1;
        end
        if (if_ready && !ls_req) begin
            fetch_from_array = 1'b1;
            fetch_word       = mem[if_line];
        end
    end

    always_ff @(posedge clock) begin
        if (store && !reset) begin
            mem[ls_line] <= ls_data_input;
        end
    end

    always_ff @(posedge clock) begin
        ls_pipe[0] <= mem[ls_line];
        if_pipe[0] <= fetch_word;
        for (int k = 1; k < RD_LAT; k++) begin
            ls_pipe[k] <= ls_pipe[k-1];
            if_pipe[k] <= if_pipe[k-1];
        end
    end

    // Only the valid bits need clearing: stale pipeline data is never presented without them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ls_vld         <= '0;
            if_vld         <= '0;
            ls_rvalid      <= 1'b0;
            if_rvalid      <= 1'b0;
            ls_data_output <= '0;
            if_data        <= '0;
            buf_valid      <= 1'b0;
            buf_tag        <= '0;
            buf_data       <= '0;
        end else begin
            ls_vld[0] <= load;
            if_vld[0] <= if_ready;
            for (int k = 1; k < RD_LAT; k++) begin
                ls_vld[k] <= ls_vld[k-1];
                if_vld[k] <= if_vld[k-1];
            end

            ls_rvalid <= ls_vld[RD_LAT-1];
            if_rvalid <= if_vld[RD_LAT-1];
            if (ls_vld[RD_LAT-1]) begin
                ls_data_output <= ls_pipe[RD_LAT-1];
            end
            if (if_vld[RD_LAT-1]) begin
                if_data <= if_pipe[RD_LAT-1];
            end

            if (fetch_from_array) begin
                buf_valid <= 1'b1;
                buf_tag   <= if_line;
                buf_data  <= mem[if_line];
            end else if (store && (ls_line == buf_tag)) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_local_store_responder.sv
// Directed table-driven bench for local_store_responder (default ADDR_W=15, RD_LAT=2);
// each row is driven for one cycle and the outputs are compared mid-cycle.
module tb_local_store_responder;

    logic         clock;
    logic         reset;
    logic         ls_req;
    logic         ls_wrt_en;
    logic [14:0]  ls_address;
    logic [127:0] ls_data_input;
    logic [127:0] ls_data_output;
    logic         ls_rvalid;
    logic         if_req;
    logic [14:0]  if_address;
    logic         if_ready;
    logic [127:0] if_data;
    logic         if_rvalid;

    int checks;
    int failures;

    localparam logic [127:0] Z  = 128'h0;
    localparam logic [127:0] DA = {16{8'hA5}};
    localparam logic [127:0] D2 = {4{32'h2222_0002}};
    localparam logic [127:0] D3 = {4{32'h3333_0003}};
    localparam logic [127:0] DF = {4{32'hF00D_0100}};
    localparam logic [127:0] DN = {4{32'hBEEF_0101}};
    localparam logic [127:0] DG = {4{32'h6060_0200}};

    typedef struct {
        logic         ls_req;
        logic         ls_wr;
        logic [14:0]  ls_addr;
        logic [127:0] din;
        logic         if_req;
        logic [14:0]  if_addr;
        logic         ifr;
        logic         lsv;
        logic [127:0] lsd;
        logic         ifv;
        logic [127:0] ifd;
    } vec_t;

    vec_t tbl1[$];
    vec_t tbl2[$];

    local_store_responder dut (
        .clock          (clock),
        .reset          (reset),
        .ls_req         (ls_req),
        .ls_wrt_en      (ls_wrt_en),
        .ls_address     (ls_address),
        .ls_data_input  (ls_data_input),
        .ls_data_output (ls_data_output),
        .ls_rvalid      (ls_rvalid),
        .if_req         (if_req),
        .if_address     (if_address),
        .if_ready       (if_ready),
        .if_data        (if_data),
        .if_rvalid      (if_rvalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic a_ls_req, input logic a_ls_wr, input logic [14:0] a_ls_addr,
                                input logic [127:0] a_din, input logic a_if_req, input logic [14:0] a_if_addr,
                                input logic a_ifr, input logic a_lsv, input logic [127:0] a_lsd,
                                input logic a_ifv, input logic [127:0] a_ifd);
        vec_t v;
        v.ls_req  = a_ls_req;
        v.ls_wr   = a_ls_wr;
        v.ls_addr = a_ls_addr;
        v.din     = a_din;
        v.if_req  = a_if_req;
        v.if_addr = a_if_addr;
        v.ifr     = a_ifr;
        v.lsv     = a_lsv;
        v.lsd     = a_lsd;
        v.ifv     = a_ifv;
        v.ifd     = a_ifd;
        return v;
    endfunction

    task automatic check1(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        ls_req        = v.ls_req;
        ls_wrt_en     = v.ls_wr;
        ls_address    = v.ls_addr;
        ls_data_input = v.din;
        if_req        = v.if_req;
        if_address    = v.if_addr;
    endtask

    task automatic check_output(input vec_t v, input string tag, input int idx);
        check1($sformatf("%s[%0d].if_ready", tag, idx), {127'b0, if_ready}, {127'b0, v.ifr});
        check1($sformatf("%s[%0d].ls_rvalid", tag, idx), {127'b0, ls_rvalid}, {127'b0, v.lsv});
        check1($sformatf("%s[%0d].ls_data_output", tag, idx), ls_data_output, v.lsd);
        check1($sformatf("%s[%0d].if_rvalid", tag, idx), {127'b0, if_rvalid}, {127'b0, v.ifv});
        check1($sformatf("%s[%0d].if_data", tag, idx), if_data, v.ifd);
    endtask

    task automatic run_row(input vec_t v, input string tag, input int idx);
        @(negedge clock);
        apply_stimulus(v);
        #1;
        check_output(v, tag, idx);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // ls_req ls_wr ls_addr din if_req if_addr | ifr lsv lsd ifv ifd
        tbl1.push_back(mk(1, 1, 15'h0010, DA, 0, 15'h0000, 0, 0, Z,  0, Z));   // r0 store A line 1
        tbl1.push_back(mk(1, 0, 15'h001F, Z,  0, 15'h0000, 0, 0, Z,  0, Z));   // r1 load line 1
        tbl1.push_back(mk(1, 1, 15'h0020, D2, 0, 15'h0000, 0, 0, Z,  0, Z));   // r2
        tbl1.push_back(mk(1, 1, 15'h0030, D3, 0, 15'h0000, 0, 0, Z,  0, Z));   // r3
        tbl1.push_back(mk(0, 0, 15'h0000, Z,  0, 15'h0000, 0, 1, DA, 0, Z));   // r4 RAW response
        tbl1.push_back(mk(1, 0, 15'h0010, Z,  0, 15'h0000, 0, 0, DA, 0, Z));   // r5 back-to-back loads
        tbl1.push_back(mk(1, 0, 15'h0020, Z,  0, 15'h0000, 0, 0, DA, 0, Z));   // r6
        tbl1.push_back(mk(1, 0, 15'h0030, Z,  0, 15'h0000, 0, 0, DA, 0, Z));   // r7
        tbl1.push_back(mk(1, 1, 15'h0100, DF, 0, 15'h0000, 0, 1, DA, 0, Z));   // r8
        tbl1.push_back(mk(0, 0, 15'h0000, Z,  1, 15'h0100, 1, 1, D2, 0, Z));   // r9 fetch, ls idle
        tbl1.push_back(mk(1, 0, 15'h0010, Z,  1, 15'h0100, 1, 1, D3, 0, Z));   // r10 buffer hit
        tbl1.push_back(mk(1, 1, 15'h0200, DG, 0, 15'h0000, 0, 0, D3, 0, Z));   // r11
        tbl1.push_back(mk(1, 1, 15'h0100, DN, 1, 15'h0100, 0, 0, D3, 1, DF));  // r12 store+fetch same line
        tbl1.push_back(mk(0, 0, 15'h0000, Z,  1, 15'h0100, 1, 1, DA, 1, DF));  // r13 refetch from array
        tbl1.push_back(mk(0, 0, 15'h0000, Z,  0, 15'h0000, 0, 0, DA, 0, DF));  // r14
        tbl1.push_back(mk(0, 0, 15'h0000, Z,  0, 15'h0000, 0, 0, DA, 0, DF));  // r15
        tbl1.push_back(mk(0, 0, 15'h0000, Z,  0, 15'h0000, 0, 0, DA, 1, DN));  // r16 new data
        for (int i = 0; i < 3; i++)                                             // r17..r19 fetch stalls
            tbl1.push_back(mk(1, 0, 15'h0020, Z, 1, 15'h0200, 0, 0, DA, 0, DN));
        for (int i = 0; i < 2; i++)                                             // r20..r21
            tbl1.push_back(mk(1, 0, 15'h0020, Z, 1, 15'h0200, 0, 1, D2, 0, DN));
        tbl1.push_back(mk(0, 0, 15'h0000, Z,  1, 15'h0200, 1, 1, D2, 0, DN));  // r22 accepted on 6th
        tbl1.push_back(mk(0, 0, 15'h0000, Z,  0, 15'h0000, 0, 1, D2, 0, DN));  // r23
        tbl1.push_back(mk(0, 0, 15'h0000, Z,  0, 15'h0000, 0, 1, D2, 0, DN));  // r24
        tbl1.push_back(mk(0, 0, 15'h0000, Z,  0, 15'h0000, 0, 0, D2, 1, DG));  // r25
        tbl1.push_back(mk(0, 0, 15'h0000, Z,  0, 15'h0000, 0, 0, D2, 0, DG));  // r26
        tbl1.push_back(mk(1, 0, 15'h0010, Z,  0, 15'h0000, 0, 0, D2, 0, DG));  // r27 loads then reset
        tbl1.push_back(mk(1, 0, 15'h0020, Z,  0, 15'h0000, 0, 0, D2, 0, DG));  // r28

        tbl2.push_back(mk(0, 0, 15'h0000, Z,  0, 15'h0000, 0, 0, Z,  0, Z));   // p0
        tbl2.push_back(mk(0, 0, 15'h0000, Z,  0, 15'h0000, 0, 0, Z,  0, Z));   // p1
        tbl2.push_back(mk(1, 0, 15'h0030, Z,  1, 15'h0200, 0, 0, Z,  0, Z));   // p2 buffer cleared
        tbl2.push_back(mk(1, 0, 15'h0010, Z,  0, 15'h0000, 0, 0, Z,  0, Z));   // p3
        tbl2.push_back(mk(0, 0, 15'h0000, Z,  0, 15'h0000, 0, 0, Z,  0, Z));   // p4
        tbl2.push_back(mk(0, 0, 15'h0000, Z,  0, 15'h0000, 0, 1, D3, 0, Z));   // p5 array retained
        tbl2.push_back(mk(0, 0, 15'h0000, Z,  0, 15'h0000, 0, 1, DA, 0, Z));   // p6
        tbl2.push_back(mk(0, 0, 15'h0000, Z,  1, 15'h0200, 1, 0, DA, 0, Z));   // p7 fetch from array
        tbl2.push_back(mk(0, 0, 15'h0000, Z,  0, 15'h0000, 0, 0, DA, 0, Z));   // p8
        tbl2.push_back(mk(0, 0, 15'h0000, Z,  0, 15'h0000, 0, 0, DA, 0, Z));   // p9
        tbl2.push_back(mk(0, 0, 15'h0000, Z,  0, 15'h0000, 0, 0, DA, 1, DG));  // p10

        // Power-up reset with a fetch already requesting.
        reset         = 1'b1;
        ls_req        = 1'b0;
        ls_wrt_en     = 1'b0;
        ls_address    = '0;
        ls_data_input = '0;
        if_req        = 1'b1;
        if_address    = 15'h0100;
        #2;
        check1("reset.if_ready", {127'b0, if_ready}, 128'h0);
        check1("reset.ls_rvalid", {127'b0, ls_rvalid}, 128'h0);
        check1("reset.if_rvalid", {127'b0, if_rvalid}, 128'h0);
        check1("reset.ls_data_output", ls_data_output, Z);
        check1("reset.if_data", if_data, Z);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset  = 1'b0;
        if_req = 1'b0;

        for (int i = 0; i < tbl1.size(); i++) run_row(tbl1[i], "main", i);

        // Two loads are in flight here; reset must drop them and clear the outputs.
        @(negedge clock);
        ls_req     = 1'b0;
        ls_wrt_en  = 1'b0;
        if_req     = 1'b1;
        if_address = 15'h0200;
        reset      = 1'b1;
        #1;
        check1("midreset.ls_rvalid", {127'b0, ls_rvalid}, 128'h0);
        check1("midreset.ls_data_output", ls_data_output, Z);
        check1("midreset.if_data", if_data, Z);
        check1("midreset.if_rvalid", {127'b0, if_rvalid}, 128'h0);
        check1("midreset.if_ready", {127'b0, if_ready}, 128'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            check1($sformatf("inreset[%0d].ls_rvalid", i), {127'b0, ls_rvalid}, 128'h0);
            check1($sformatf("inreset[%0d].if_ready", i), {127'b0, if_ready}, 128'h0);
        end
        @(negedge clock);
        reset  = 1'b0;
        if_req = 1'b0;

        for (int i = 0; i < tbl2.size(); i++) run_row(tbl2[i], "post", i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
